// File: rtl/levit_stage_sequencer.sv
// ---------------------------------------------------------------------------
// levit_stage_sequencer
//
// Central scheduler for the Tiny_LeViT inference pipeline. One FSM walks the
// twelve pipeline units (conv16, conv8, conv4, 2-head stages 1-4, 4-head
// stages 5-8, avg pool) with a one-hot enable. Each unit is released by its
// own end pulse, and the next unit is enabled on the same edge. There are no
// gap cycles and no overlap cycles between units. The FSM also provides a
// start/done frame handshake, abort, a per-stage watchdog and a frame counter.
//
// Optional build macro:
//   SEQ_PERF_EN - adds a per-stage cycle-count register file with a registered
//                 read port (perf_sel / perf_cycles).
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   start        in   frame request, sampled only in IDLE
//   abort        in   cancel the current frame (RUN) or clear ERR
//   stage_end    in   [NUM_STAGES] end pulses from the units
//   stage_en     out  [NUM_STAGES] one-hot unit enables
//   stage_en_d1  out  [NUM_STAGES] stage_en delayed one cycle
//   cur_stage    out  [4] index of the enabled stage, 0 when not running
//   busy         out  high while any stage is enabled
//   done         out  one-cycle pulse when a frame completes
//   err_timeout  out  sticky watchdog-expiry flag, cleared only by rst
//   frame_cnt    out  [FRAME_W] frames completed since reset
//   perf_sel     in   [4] perf entry select          (SEQ_PERF_EN only)
//   perf_cycles  out  [WD_W] registered entry read   (SEQ_PERF_EN only)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame active; waits for start
// RUN   | stage idx_q enabled; watchdog counts cycles without its end
// DONE  | single cycle after the last stage end; done pulse
// ERR   | watchdog expired; enables off until abort or rst
// ---------------------------------------------------------------------------
module levit_stage_sequencer #(
    parameter int              NUM_STAGES = 12,
    parameter int              WD_W       = 20,
    parameter logic [WD_W-1:0] WD_LIMIT   = 20'hFFFFF,
    parameter int              FRAME_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_end,
`ifdef SEQ_PERF_EN
    input  logic [3:0]            perf_sel,
    output logic [WD_W-1:0]       perf_cycles,
`endif
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_en_d1,
    output logic [3:0]            cur_stage,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic [FRAME_W-1:0]    frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_STAGES - 1);

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic                    err_q, err_d;
    logic [NUM_STAGES-1:0]   en_d1_q;
    logic                    end_cur;

    // Only the end pulse of the enabled unit matters. All other bits are
    // spurious and are dropped here.
    assign end_cur = stage_end[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            wd_q    <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            en_d1_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            en_d1_q <= stage_en;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        frame_d = frame_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = 4'd0;
                    wd_d    = '0;
                end
            end

            S_RUN: begin
                // abort beats a stage end, and a stage end beats the watchdog.
                if (abort) begin
                    state_d = S_IDLE;
                    idx_d   = 4'd0;
                    wd_d    = '0;
                end else if (end_cur) begin
                    wd_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        idx_d   = 4'd0;
                        frame_d = frame_q + FRAME_W'(1);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    state_d = S_ERR;
                    idx_d   = 4'd0;
                    wd_d    = '0;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                if (abort) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
                wd_d    = '0;
            end
        endcase
    end

    // Enables are decoded from registered state, so they change only on clock
    // edges. The hand-over between units happens inside a single edge.
    assign stage_en    = (state_q == S_RUN) ? (NUM_STAGES'(1) << idx_q) : '0;
    assign stage_en_d1 = en_d1_q;
    assign cur_stage   = (state_q == S_RUN) ? idx_q : 4'd0;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign err_timeout = err_q;
    assign frame_cnt   = frame_q;

`ifdef SEQ_PERF_EN
    logic [WD_W-1:0] perf_mem [NUM_STAGES];
    logic [WD_W-1:0] perf_q;

    // The watchdog holds the number of cycles already spent in the stage.
    // Adding 1 counts the end cycle as well. Entries are written only on a
    // real stage end, so an aborted stage keeps the value from its last
    // completed run.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                perf_mem[i] <= '0;
            end
            perf_q <= '0;
        end else begin
            if (state_q == S_RUN && !abort && end_cur) begin
                perf_mem[idx_q] <= wd_q + WD_W'(1);
            end
            perf_q <= (32'(perf_sel) < 32'(NUM_STAGES)) ? perf_mem[perf_sel] : '0;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_levit_stage_sequencer.sv
module tb_levit_stage_sequencer;

    localparam int N = 12;
`ifdef SEQ_PERF_EN
    localparam int TB_WD = 16;
`else
    localparam int TB_WD = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] stage_end = '0;
    logic [3:0]  perf_sel = '0;
    logic [11:0] stage_en, stage_en_d1;
    logic [3:0]  cur_stage;
    logic        busy, done, err_timeout;
    logic [15:0] frame_cnt;
`ifdef SEQ_PERF_EN
    logic [19:0] perf_cycles;
`endif

    levit_stage_sequencer #(
        .NUM_STAGES(N),
        .WD_W(20),
        .WD_LIMIT(20'(TB_WD)),
        .FRAME_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .stage_end(stage_end),
`ifdef SEQ_PERF_EN
        .perf_sel(perf_sel),
        .perf_cycles(perf_cycles),
`endif
        .stage_en(stage_en),
        .stage_en_d1(stage_en_d1),
        .cur_stage(cur_stage),
        .busy(busy),
        .done(done),
        .err_timeout(err_timeout),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: which stage is enabled (-1 for none), and for how
    // many cycles it has been enabled so far, counting the current cycle.
    int          m_stage = -1;
    int          m_age = 0;
    bit          m_done = 0;
    bit          m_in_err = 0;
    bit          m_err = 0;
    int          m_frames = 0;
    logic [11:0] m_prev_en = '0;
    int          m_perf[N];
    int          m_perf_q = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] exp_en();
        logic [11:0] v;
        v = '0;
        if (m_stage >= 0) v[m_stage] = 1'b1;
        return v;
    endfunction

    task automatic check_outputs();
        check_val("stage_en", 32'(stage_en), 32'(exp_en()));
        check_val("stage_en_d1", 32'(stage_en_d1), 32'(m_prev_en));
        check_val("cur_stage", 32'(cur_stage), (m_stage >= 0) ? m_stage : 0);
        check_val("busy", 32'(busy), 32'(m_stage >= 0));
        check_val("done", 32'(done), 32'(m_done));
        check_val("err_timeout", 32'(err_timeout), 32'(m_err));
        check_val("frame_cnt", 32'(frame_cnt), m_frames);
`ifdef SEQ_PERF_EN
        check_val("perf_cycles", 32'(perf_cycles), m_perf_q);
`endif
    endtask

    task automatic model_update(input logic st, input logic ab, input logic rs,
                                input logic [11:0] se, input logic [3:0] sel);
        logic [11:0] cur_en;
        cur_en = exp_en();
        if (rs) begin
            m_stage = -1; m_age = 0; m_done = 0; m_in_err = 0; m_err = 0;
            m_frames = 0; m_prev_en = '0; m_perf_q = 0;
            for (int i = 0; i < N; i++) m_perf[i] = 0;
            return;
        end
        m_perf_q = (int'(sel) < N) ? m_perf[sel] : 0;
        m_prev_en = cur_en;
        if (m_done) begin
            m_done = 0;
        end else if (m_in_err) begin
            if (ab) m_in_err = 0;
        end else if (m_stage < 0) begin
            if (st) begin
                m_stage = 0;
                m_age = 1;
            end
        end else if (ab) begin
            m_stage = -1;
        end else if (se[m_stage]) begin
            m_perf[m_stage] = m_age;
            if (m_stage == N - 1) begin
                m_stage = -1;
                m_done = 1;
                m_frames = (m_frames + 1) % 65536;
            end else begin
                m_stage++;
                m_age = 1;
            end
        end else if (m_age - 1 == TB_WD) begin
            m_stage = -1;
            m_in_err = 1;
            m_err = 1;
        end else begin
            m_age++;
        end
    endtask

    // Check the outputs at the negedge, drive the inputs, and advance one edge.
    task automatic step(input logic st, input logic ab, input logic rs,
                        input logic [11:0] se, input logic [3:0] sel);
        check_outputs();
        start = st; abort = ab; rst = rs; stage_end = se; perf_sel = sel;
        @(posedge clk);
        model_update(st, ab, rs, se, sel);
        cyc++;
        @(negedge clk);
    endtask

    // Start a frame in which stage k lasts base+inc*k cycles. The stage named
    // by hang never ends. Spurious end bits and start pulses are sprinkled in.
    task automatic run_frame(input int base, input int inc, input int hang,
                             output int done_at, output int hang_cnt);
        int t0;
        int j;
        logic [11:0] se;
        done_at = -1;
        hang_cnt = 0;
        t0 = cyc;
        step(1'b1, 1'b0, 1'b0, '0, 4'($urandom_range(15)));
        for (int i = 0; i < 600; i++) begin
            if (hang >= 0 && stage_en[hang] === 1'b1) hang_cnt++;
            if (done === 1'b1) begin
                done_at = cyc - t0;
                break;
            end
            if (m_in_err) break;
            se = '0;
            if (m_stage >= 0 && m_stage != hang && m_age == base + inc * m_stage)
                se[m_stage] = 1'b1;
            if (m_stage == 3 && m_age == 2) se = se | 12'h084;
            j = $urandom_range(N - 1);
            if ($urandom_range(2) == 0 && j != m_stage) se[j] = 1'b1;
            step(1'($urandom_range(1)), 1'b0, 1'b0, se, 4'($urandom_range(15)));
        end
    endtask

    initial begin
        int d, h;
        logic [11:0] se;
        logic st, ab, rs;

        for (int i = 0; i < N; i++) m_perf[i] = 0;
        @(posedge clk);
        model_update(1'b0, 1'b0, 1'b1, '0, '0);
        @(negedge clk);
        step(1'b0, 1'b0, 1'b1, 12'hFFF, '0);
        step(1'b0, 1'b0, 1'b0, 12'hFFF, '0);

        // Nominal frame: every stage lasts 5 cycles, with spurious ends in stage 3.
        run_frame(5, 0, -1, d, h);
        check_val("nom_done_cycle", d, 61);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        check_val("start_in_done_ignored", 32'(busy), 0);
        check_val("nom_frame_cnt", 32'(frame_cnt), 1);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        // Watchdog: stage 4 hangs.
        run_frame(3, 0, 4, d, h);
        check_val("wd_en_cycles", h, TB_WD + 1);
        check_val("wd_err_set", 32'(err_timeout), 1);
        check_val("wd_en_off", 32'(stage_en), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'hFFF, '0);
        check_val("start_in_err_ignored", 32'(busy), 0);
        step(1'b0, 1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(4, 0, -1, d, h);
        check_val("post_err_done_cycle", d, 1 + 12 * 4);
        check_val("err_sticky", 32'(err_timeout), 1);
        check_val("post_err_frame_cnt", 32'(frame_cnt), 2);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        // A stage end in the same cycle as watchdog expiry advances normally.
        step(1'b0, 1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        run_frame(TB_WD + 1, 0, -1, d, h);
        check_val("coinc_done_cycle", d, 1 + 12 * (TB_WD + 1));
        check_val("coinc_no_err", 32'(err_timeout), 0);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        // abort coinciding with stage_end: back to IDLE, no done.
        step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 40 && !(m_stage == 2 && m_age == 2); i++)
            step(1'b0, 1'b0, 1'b0, (m_stage >= 0 && m_age == 3) ? exp_en() : 12'h000, '0);
        check_val("abort_reached_stage2", 32'(cur_stage), 2);
        step(1'b0, 1'b1, 1'b0, 12'h004, '0);
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_no_done", 32'(done), 0);
        check_val("abort_frame_cnt", 32'(frame_cnt), 1);
        step(1'b0, 1'b0, 1'b0, '0, '0);

        // rst in the middle of stage 6.
        step(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 60 && !(m_stage == 6 && m_age == 2); i++)
            step(1'b0, 1'b0, 1'b0, (m_stage >= 0 && m_age == 3) ? exp_en() : 12'h000, '0);
        check_val("rst_reached_stage6", 32'(cur_stage), 6);
        step(1'b0, 1'b0, 1'b1, '0, '0);
        check_val("rst_en", 32'(stage_en), 0);
        check_val("rst_frame_cnt", 32'(frame_cnt), 0);
        step(1'b0, 1'b0, 1'b0, '0, '0);

`ifdef SEQ_PERF_EN
        // Stage k lasts k+2 cycles, then entries 0..11 and 15 are read back.
        run_frame(2, 1, -1, d, h);
        check_val("perf_done_cycle", d, 1 + 90);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < N; k++) begin
            step(1'b0, 1'b0, 1'b0, '0, 4'(k));
            check_val("perf_rd", 32'(perf_cycles), k + 2);
        end
        step(1'b0, 1'b0, 1'b0, '0, 4'd15);
        check_val("perf_rd_oor", 32'(perf_cycles), 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(399) == 0);
            ab = ($urandom_range(49) == 0);
            st = ab ? 1'b0 : ($urandom_range(7) == 0);
            se = 12'($urandom & $urandom & $urandom);
            if (m_stage >= 0 && $urandom_range(3) == 0) se[m_stage] = 1'b1;
            step(st, ab, rs, se, 4'($urandom_range(15)));
        end
        step(1'b0, 1'b0, 1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
